spi_slave_if: RTL
=================

Name: spi_slave_if

Overview:
- SPI mode-0 slave front end for the PWM generator's register interface; sits directly upstream of the instruction decoder.
- Samples the external SPI pins (sclk, cs_n, mosi) into the peripheral clock domain and deserialises MOSI bytes.
- Presents each completed byte to the decoder as a one-cycle byte_sync pulse with data_in.
- Serialises the decoder's data_out back onto MISO, MSB first.

Parameters:
- SYNC_STAGES, 2, flops in each pin synchroniser (sclk, cs_n, mosi); minimum 2.

Ports:
- clk  in  1  peripheral clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock, async to clk; idle low; period ≥ 16 clk periods.
- cs_n  in  1  SPI chip select, active low, async.
- mosi  in  1  SPI data in, async.
- miso  out  1  SPI data out.
- miso_oe  out  1  1 while a frame is active (pad tri-state enable).
- byte_sync  out  1  one-cycle pulse: data_in holds a new byte.
- data_in  out  8  last completed MOSI byte, to decoder.
- data_out  in  8  byte to transmit, from decoder.
- frame_err  out  1  one-cycle pulse: frame ended on a non-byte boundary.

Behaviour:
- Reset values:
  - byte_sync, frame_err, miso, miso_oe = 0; data_in = 8'h00.
  - Internal: bit counter = 0, rx/tx shift registers = 0, state = IDLE.
  - All synchroniser flops = 0, including cs_n. A frame already in progress at reset release is therefore ignored until cs_n goes high and then low again.
- Edge detection: each pin passes through SYNC_STAGES flops. Edges are found by comparing the last synchroniser stage with one extra registered copy. Edge-to-detect latency is SYNC_STAGES+1 clk cycles.
- FSM states:
  - IDLE -> ACTIVE on detected cs_n falling edge. On entry: bit counter = 0, tx shift register loaded from data_out, miso = data_out[7], miso_oe = 1.
  - ACTIVE, detected sclk rising edge: rx_shift = {rx_shift[6:0], mosi_synced}; bit counter + 1.
    - When the counter reaches 8 it wraps to 0. In the next clk cycle: byte_sync = 1 for exactly one cycle, data_in = completed byte. data_in holds until the next completed byte.
  - ACTIVE, detected sclk falling edge:
    - Counter != 0: tx shifts left and miso = next bit.
    - Counter == 0 (falling edge ending a byte): tx reloaded from the current data_out and miso = data_out[7].
  - ACTIVE -> IDLE on detected cs_n rising edge. miso_oe = 0, miso = 0.
    - If bit counter != 0: frame_err pulses for one cycle, the partial byte is discarded, and there is no byte_sync.
- Read-data timing:
  - The decoder updates data_out 2 clk cycles after byte_sync.
  - With sclk ≥ 16 clk periods, the reload on the next falling edge always sees the updated data_out.
  - So the MISO byte N+1 carries data_out as it stood after byte N completed.
- Simultaneous events (same clk cycle):
  - sclk rising and cs_n rising: the sclk edge is processed first. If it completes byte 8, byte_sync is still issued and frame_err is not.
  - sclk falling and cs_n rising: the frame ends and the shift is ignored.
- Outside ACTIVE, sclk and mosi edges are ignored. No byte_sync is ever issued in IDLE.
- A cs_n falling edge in ACTIVE is impossible (cs_n is already low); no special handling.
- byte_sync and frame_err are never asserted together.
- Bytes in a frame: unlimited. The counter wraps every 8 bits and each byte yields one byte_sync.

Test Plan:
- Reset, then 2-byte frame with MOSI 0x85, 0x3C, sclk = clk/16 -> two byte_sync pulses, data_in = 0x85 then 0x3C, frame_err never set, miso_oe high only between the cs_n edges.
- data_out = 0xA5 before cs_n falls; clock 8 bits -> master samples 0xA5 on MISO. Change data_out to 0x5A within 2 cycles after the first byte_sync -> second byte on MISO reads 0x5A.
- Frame of 5 bits then cs_n high -> no byte_sync, one frame_err pulse. A following clean frame with 0x12 -> byte_sync with data_in = 0x12.
- cs_n rising in the same clk cycle as the detected 8th sclk rise -> byte_sync = 1, frame_err = 0, state IDLE.
- Assert rst mid-byte (bit 4) while cs_n stays low, release and keep clocking sclk -> no byte_sync or frame_err. cs_n high then low, send 0xFF -> data_in = 0xFF.
- sclk/mosi toggling with cs_n high -> byte_sync stays 0, miso = 0, miso_oe = 0.

Source files
------------

// File: rtl/spi_slave_if.sv
// ============================================================================
// spi_slave_if : SPI mode-0 slave front end (pin sync, byte deserialiser,
//                MISO serialiser) for the PWM register decoder.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       frame_err
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;

  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_rise;
  logic       cs_fall;
  logic [7:0] rx_next;
  logic [2:0] bit_cnt_after;

  // cs_n synchroniser also resets to 0, so a frame live at reset release
  // is not seen until cs_n returns high and falls again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s        = sclk_sync[SYNC_STAGES-1];
  assign cs_s          = cs_sync[SYNC_STAGES-1];
  assign mosi_s        = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise     = sclk_s & ~sclk_d;
  assign sclk_fall     = ~sclk_s & sclk_d;
  assign cs_rise       = cs_s & ~cs_d;
  assign cs_fall       = ~cs_s & cs_d;
  assign rx_next       = {rx_shift[6:0], mosi_s};
  assign bit_cnt_after = bit_cnt + {2'b00, sclk_rise};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      byte_sync <= 1'b0;
      frame_err <= 1'b0;
      data_in   <= 8'h00;
    end else begin
      byte_sync <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= data_out;
            miso     <= data_out[7];
            miso_oe  <= 1'b1;
          end
        end
        ACTIVE: begin
          // A rising sclk is honoured even when cs_n rises in the same cycle.
          if (sclk_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt_after;
            if (bit_cnt == 3'd7) begin
              byte_sync <= 1'b1;
              data_in   <= rx_next;
            end
          end
          if (cs_rise) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            if (bit_cnt_after != 3'd0) begin
              frame_err <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              miso     <= tx_shift[6];
            end else begin
              tx_shift <= data_out;
              miso     <= data_out[7];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
